// File: rtl/hawk_comdecomp_pkg.sv
// +------------------------------------------------------------------------+
// | hawk_comdecomp_pkg : shared types for the page compress/decompress path |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
`default_nettype none

package hawk_comdecomp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMP   = 2'd1,
    DECOMP = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic {
    MODE_BYPASS    = 1'b0,
    MODE_ZERO_ELIM = 1'b1
  } mode_t;

  function automatic int beat_bytes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hawk_comdecomp_engine_if.sv
// +------------------------------------------------------------------------+
// | hawk_comdecomp_engine_if : read-FIFO / write-FIFO bus of the engine     |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
`default_nettype none

interface hawk_comdecomp_engine_if #(
  parameter int DATA_W = 512
);

  logic [DATA_W-1:0] rdfifo_data_i;
  logic              rdfifo_empty_i;
  logic              rdfifo_rready_o;
  logic [DATA_W-1:0] wrfifo_data_o;
  logic              wrfifo_valid_o;
  logic              wrfifo_full_i;

  // Suffixes are from the engine's point of view.
  modport master (
    input  rdfifo_data_i,
    input  rdfifo_empty_i,
    input  wrfifo_full_i,
    output rdfifo_rready_o,
    output wrfifo_data_o,
    output wrfifo_valid_o
  );

  modport slave (
    output rdfifo_data_i,
    output rdfifo_empty_i,
    output wrfifo_full_i,
    input  rdfifo_rready_o,
    input  wrfifo_data_o,
    input  wrfifo_valid_o
  );

endinterface

`default_nettype wire

// File: rtl/hawk_comdecomp_engine.sv
// +------------------------------------------------------------------------+
// | hawk_comdecomp_engine : zero-beat elimination page compress/decompress  |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
`default_nettype none

module hawk_comdecomp_engine
  import hawk_comdecomp_pkg::*;
#(
  parameter int DATA_W     = 512,
  parameter int PAGE_BEATS = 64,
  parameter int SIZE_W     = 14
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  comp_start_i,
  input  logic                  decomp_start_i,
  input  logic                  mode_i,
  input  logic [PAGE_BEATS-1:0] decomp_bitmap_i,
  hawk_comdecomp_engine_if.master fifo_if,
  output logic [SIZE_W-1:0]     comp_size_o,
  output logic [PAGE_BEATS-1:0] zero_bitmap_o,
  output logic                  comp_done_o,
  output logic                  decomp_done_o,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int IDX_W = $clog2(PAGE_BEATS);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [SIZE_W-1:0] BEAT_BYTES = SIZE_W'(beat_bytes(DATA_W));
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(PAGE_BEATS - 1);

  state_t                state_q,       state_d;
  mode_t                 mode_q,        mode_d;
  logic                  op_comp_q,     op_comp_d;
  logic [PAGE_BEATS-1:0] bitmap_q,      bitmap_d;
  logic [IDX_W-1:0]      idx_q,         idx_d;
  logic [CNT_W-1:0]      nz_q,          nz_d;
  logic [SIZE_W-1:0]     comp_size_q,   comp_size_d;
  logic [PAGE_BEATS-1:0] zero_bitmap_q, zero_bitmap_d;

  logic rd_pop;
  logic wr_en;
  logic wr_zero;
  logic start_err;
  logic beat_is_zero;
  logic dec_zero_beat;

  assign beat_is_zero  = (fifo_if.rdfifo_data_i == '0);
  // The held bitmap is already forced to zero for bypass decompression.
  assign dec_zero_beat = bitmap_q[idx_q];

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    op_comp_d     = op_comp_q;
    bitmap_d      = bitmap_q;
    idx_d         = idx_q;
    nz_d          = nz_q;
    comp_size_d   = comp_size_q;
    zero_bitmap_d = zero_bitmap_q;
    rd_pop        = 1'b0;
    wr_en         = 1'b0;
    wr_zero       = 1'b0;
    start_err     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (comp_start_i) begin
          state_d       = COMP;
          mode_d        = mode_t'(mode_i);
          op_comp_d     = 1'b1;
          idx_d         = '0;
          nz_d          = '0;
          comp_size_d   = '0;
          zero_bitmap_d = '0;
          start_err     = decomp_start_i;
        end else if (decomp_start_i) begin
          state_d   = DECOMP;
          mode_d    = mode_t'(mode_i);
          op_comp_d = 1'b0;
          idx_d     = '0;
          nz_d      = '0;
          bitmap_d  = mode_i ? decomp_bitmap_i : '0;
        end
      end

      COMP: begin
        start_err = comp_start_i | decomp_start_i;
        // Full stalls even zero beats so a bypass page never overtakes.
        rd_pop = !fifo_if.rdfifo_empty_i && !fifo_if.wrfifo_full_i;
        if (rd_pop) begin
          zero_bitmap_d[idx_q] = beat_is_zero;
          wr_en = (mode_q == MODE_BYPASS) || !beat_is_zero;
          if (wr_en) begin
            nz_d = nz_q + 1'b1;
          end
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d     = DONE;
            comp_size_d = SIZE_W'(nz_d) * BEAT_BYTES;
          end
        end
      end

      DECOMP: begin
        start_err = comp_start_i | decomp_start_i;
        if (dec_zero_beat) begin
          wr_en   = !fifo_if.wrfifo_full_i;
          wr_zero = 1'b1;
        end else begin
          rd_pop = !fifo_if.rdfifo_empty_i && !fifo_if.wrfifo_full_i;
          wr_en  = rd_pop;
        end
        if (wr_en) begin
          idx_d = idx_q + 1'b1;
          if (!dec_zero_beat) begin
            nz_d = nz_q + 1'b1;
          end
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        start_err = comp_start_i | decomp_start_i;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      mode_q        <= MODE_BYPASS;
      op_comp_q     <= 1'b0;
      bitmap_q      <= '0;
      idx_q         <= '0;
      nz_q          <= '0;
      comp_size_q   <= '0;
      zero_bitmap_q <= '0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      op_comp_q     <= op_comp_d;
      bitmap_q      <= bitmap_d;
      idx_q         <= idx_d;
      nz_q          <= nz_d;
      comp_size_q   <= comp_size_d;
      zero_bitmap_q <= zero_bitmap_d;
    end
  end

  assign fifo_if.rdfifo_rready_o = rd_pop;
  assign fifo_if.wrfifo_valid_o  = wr_en;
  assign fifo_if.wrfifo_data_o   = (wr_en && !wr_zero) ? fifo_if.rdfifo_data_i : '0;

  assign comp_size_o   = comp_size_q;
  assign zero_bitmap_o = zero_bitmap_q;
  assign comp_done_o   = (state_q == DONE) &&  op_comp_q;
  assign decomp_done_o = (state_q == DONE) && !op_comp_q;
  assign busy_o        = (state_q != IDLE);
  assign err_o         = start_err && !rst_i;

endmodule

`default_nettype wire

// File: tb/tb_hawk_comdecomp_engine.sv
// +------------------------------------------------------------------------+
// | tb_hawk_comdecomp_engine : directed bench for hawk_comdecomp_engine     |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_hawk_comdecomp_engine;

  localparam int DW        = 512;
  localparam int PB        = 64;
  localparam int SW        = 14;
  localparam int MEM_DEPTH = 1024;

  logic          clk;
  logic          rst;
  logic          comp_start;
  logic          decomp_start;
  logic          mode;
  logic [PB-1:0] dbitmap;
  logic          wr_full;
  logic [SW-1:0] comp_size;
  logic [PB-1:0] zbitmap;
  logic          comp_done;
  logic          decomp_done;
  logic          busy;
  logic          err;

  logic [DW-1:0] rd_mem [MEM_DEPTH];
  int            rd_len = 0;
  int            rd_ptr = 0;

  logic [DW-1:0] wr_q [$];
  int            err_cyc_q [$];
  int            cyc = 0;
  int            comp_done_cnt = 0;
  int            decomp_done_cnt = 0;
  int            err_cnt = 0;
  int            viol_cnt = 0;

  int            checks = 0;
  int            errors = 0;

  hawk_comdecomp_engine_if #(.DATA_W(DW)) fifo_if ();

  assign fifo_if.rdfifo_empty_i = (rd_ptr >= rd_len);
  assign fifo_if.rdfifo_data_i  = (rd_ptr < rd_len) ? rd_mem[rd_ptr[9:0]] : '0;
  assign fifo_if.wrfifo_full_i  = wr_full;

  hawk_comdecomp_engine #(
    .DATA_W     (DW),
    .PAGE_BEATS (PB),
    .SIZE_W     (SW)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .comp_start_i    (comp_start),
    .decomp_start_i  (decomp_start),
    .mode_i          (mode),
    .decomp_bitmap_i (dbitmap),
    .fifo_if         (fifo_if),
    .comp_size_o     (comp_size),
    .zero_bitmap_o   (zbitmap),
    .comp_done_o     (comp_done),
    .decomp_done_o   (decomp_done),
    .busy_o          (busy),
    .err_o           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model and event monitor: samples 1 ns before the rising edge, applies after it.
  always begin : mon
    logic          s_pop;
    logic          s_wr;
    logic [DW-1:0] s_data;
    @(negedge clk);
    #4;
    s_pop  = fifo_if.rdfifo_rready_o;
    s_wr   = fifo_if.wrfifo_valid_o;
    s_data = fifo_if.wrfifo_data_o;
    if (comp_done)   comp_done_cnt++;
    if (decomp_done) decomp_done_cnt++;
    if (err) begin
      err_cnt++;
      err_cyc_q.push_back(cyc);
    end
    if ((s_pop || s_wr) && wr_full) viol_cnt++;
    if (s_pop && fifo_if.rdfifo_empty_i) viol_cnt++;
    @(posedge clk);
    #1;
    if (s_pop) rd_ptr++;
    if (s_wr) wr_q.push_back(s_data);
    cyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [DW-1:0] pat(input logic [31:0] w);
    return {16{w}};
  endfunction

  task automatic load_beat(input logic [DW-1:0] b);
    rd_mem[rd_len[9:0]] = b;
    rd_len++;
  endtask

  task automatic pulse_start(input logic c, input logic d, input logic m,
                             input logic [PB-1:0] bm, output int t);
    @(negedge clk);
    comp_start   = c;
    decomp_start = d;
    mode         = m;
    dbitmap      = bm;
    t            = cyc;
    @(negedge clk);
    comp_start   = 1'b0;
    decomp_start = 1'b0;
  endtask

  // Steps cycles until the requested done pulse is visible; done_cyc stays -1 on timeout.
  task automatic wait_done(input logic want_comp, input logic rand_full, input int limit,
                           output int done_cyc, output int nfull);
    nfull    = 0;
    done_cyc = -1;
    for (int k = 0; k < limit; k++) begin
      #1;
      if (want_comp ? comp_done : decomp_done) begin
        done_cyc = cyc;
        break;
      end
      wr_full = rand_full ? 1'($urandom_range(0, 1)) : 1'b0;
      if (wr_full) nfull++;
      @(negedge clk);
    end
    wr_full = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b expected 0", busy); end
    checks++; if (comp_size !== 14'd0) begin errors++; $display("FAIL rst_size: got %0d expected 0", comp_size); end
    checks++; if (zbitmap !== 64'd0) begin errors++; $display("FAIL rst_bitmap: got %0h expected 0", zbitmap); end
    checks++; if (fifo_if.wrfifo_valid_o !== 1'b0 || fifo_if.rdfifo_rready_o !== 1'b0) begin
      errors++; $display("FAIL rst_strobes: got %0b%0b expected 00", fifo_if.wrfifo_valid_o, fifo_if.rdfifo_rready_o); end
    checks++; if (fifo_if.wrfifo_data_o !== '0) begin errors++; $display("FAIL rst_wrdata: got %0h expected 0", fifo_if.wrfifo_data_o); end
    checks++; if ({comp_done, decomp_done, err} !== 3'b000) begin
      errors++; $display("FAIL rst_pulses: got %0b expected 000", {comp_done, decomp_done, err}); end
  endtask

  task automatic test_comp_zero_elim();
    int t, d, nf, p0, w0, c0;
    p0 = rd_ptr; w0 = wr_q.size(); c0 = comp_done_cnt;
    for (int i = 0; i < PB; i++) load_beat((i % 2 == 0) ? '0 : pat(32'hA5A5_A5A5));
    pulse_start(1'b1, 1'b0, 1'b1, '0, t);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ze_busy_first: got %0b expected 1", busy); end
    wait_done(1'b1, 1'b0, 200, d, nf);
    checks++; if (d !== t + 65) begin errors++; $display("FAIL ze_latency: got %0d expected %0d", d - t, 65); end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ze_busy_after: got %0b expected 0", busy); end
    @(negedge clk);
    checks++; if (wr_q.size() - w0 !== 32) begin errors++; $display("FAIL ze_writes: got %0d expected 32", wr_q.size() - w0); end
    checks++; if (rd_ptr - p0 !== 64) begin errors++; $display("FAIL ze_pops: got %0d expected 64", rd_ptr - p0); end
    checks++; if (comp_size !== 14'd2048) begin errors++; $display("FAIL ze_size: got %0d expected 2048", comp_size); end
    checks++; if (zbitmap !== 64'h5555_5555_5555_5555) begin errors++; $display("FAIL ze_bitmap: got %0h expected 5555555555555555", zbitmap); end
    checks++; if (comp_done_cnt - c0 !== 1) begin errors++; $display("FAIL ze_done_cnt: got %0d expected 1", comp_done_cnt - c0); end
    for (int i = 0; i < 32 && w0 + i < wr_q.size(); i++) begin
      checks++; if (wr_q[w0 + i] !== pat(32'hA5A5_A5A5)) begin errors++; $display("FAIL ze_data[%0d]: got %0h expected a5 pattern", i, wr_q[w0 + i]); end
    end
  endtask

  task automatic test_comp_bypass_full();
    int t, d, nf, w0, v0;
    logic [DW-1:0] exp_b [PB];
    w0 = wr_q.size(); v0 = viol_cnt;
    for (int i = 0; i < PB; i++) begin
      for (int w = 0; w < DW / 32; w++) exp_b[i][w*32 +: 32] = $urandom;
      if (i == 5) exp_b[i] = '0;
      load_beat(exp_b[i]);
    end
    pulse_start(1'b1, 1'b0, 1'b0, '0, t);
    wait_done(1'b1, 1'b1, 400, d, nf);
    checks++; if (d !== t + 65 + nf) begin errors++; $display("FAIL byp_latency: got %0d expected %0d", d - t, 65 + nf); end
    @(negedge clk); @(negedge clk);
    checks++; if (wr_q.size() - w0 !== 64) begin errors++; $display("FAIL byp_writes: got %0d expected 64", wr_q.size() - w0); end
    checks++; if (comp_size !== 14'd4096) begin errors++; $display("FAIL byp_size: got %0d expected 4096", comp_size); end
    checks++; if (zbitmap !== 64'h20) begin errors++; $display("FAIL byp_bitmap: got %0h expected 20", zbitmap); end
    checks++; if (viol_cnt - v0 !== 0) begin errors++; $display("FAIL byp_full_violation: got %0d expected 0", viol_cnt - v0); end
    for (int i = 0; i < PB && w0 + i < wr_q.size(); i++) begin
      checks++; if (wr_q[w0 + i] !== exp_b[i]) begin errors++; $display("FAIL byp_data[%0d]: got %0h expected %0h", i, wr_q[w0 + i], exp_b[i]); end
    end
  endtask

  task automatic test_decomp_bitmap();
    int t, d, nf, p0, w0, c0, dd0;
    p0 = rd_ptr; w0 = wr_q.size(); c0 = comp_done_cnt; dd0 = decomp_done_cnt;
    for (int i = 0; i < 32; i++) load_beat(pat(32'h1000_0000 + i));
    pulse_start(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_0000_0000, t);
    wait_done(1'b0, 1'b0, 200, d, nf);
    checks++; if (d !== t + 65) begin errors++; $display("FAIL dec_latency: got %0d expected %0d", d - t, 65); end
    @(negedge clk); @(negedge clk);
    checks++; if (wr_q.size() - w0 !== 64) begin errors++; $display("FAIL dec_writes: got %0d expected 64", wr_q.size() - w0); end
    checks++; if (rd_ptr - p0 !== 32) begin errors++; $display("FAIL dec_pops: got %0d expected 32", rd_ptr - p0); end
    checks++; if (decomp_done_cnt - dd0 !== 1 || comp_done_cnt - c0 !== 0) begin
      errors++; $display("FAIL dec_done_cnt: got %0d/%0d expected 1/0", decomp_done_cnt - dd0, comp_done_cnt - c0); end
    checks++; if (comp_size !== 14'd4096 || zbitmap !== 64'h20) begin
      errors++; $display("FAIL dec_keeps_comp_state: got %0d/%0h expected 4096/20", comp_size, zbitmap); end
    for (int i = 0; i < PB && w0 + i < wr_q.size(); i++) begin
      checks++; if (wr_q[w0 + i] !== ((i < 32) ? pat(32'h1000_0000 + i) : '0)) begin
        errors++; $display("FAIL dec_data[%0d]: got %0h expected %0h", i, wr_q[w0 + i], (i < 32) ? pat(32'h1000_0000 + i) : '0); end
    end
  endtask

  task automatic test_start_conflict();
    int t, d, nf, w0, c0, dd0, e0;
    w0 = wr_q.size(); c0 = comp_done_cnt; dd0 = decomp_done_cnt; e0 = err_cnt;
    for (int i = 0; i < PB; i++) load_beat(pat(32'hC0DE_0000 + i));
    pulse_start(1'b1, 1'b1, 1'b1, '0, t);
    repeat (9) @(negedge clk);
    comp_start = 1'b1;
    @(negedge clk);
    comp_start = 1'b0;
    wait_done(1'b1, 1'b0, 200, d, nf);
    checks++; if (d !== t + 65) begin errors++; $display("FAIL conf_latency: got %0d expected %0d", d - t, 65); end
    @(negedge clk); @(negedge clk);
    checks++; if (err_cnt - e0 !== 2) begin errors++; $display("FAIL conf_err_cnt: got %0d expected 2", err_cnt - e0); end
    if (err_cnt - e0 >= 2) begin
      checks++; if (err_cyc_q[e0] !== t) begin errors++; $display("FAIL conf_err_first: got %0d expected %0d", err_cyc_q[e0] - t, 0); end
      checks++; if (err_cyc_q[e0 + 1] !== t + 10) begin errors++; $display("FAIL conf_err_second: got %0d expected %0d", err_cyc_q[e0 + 1] - t, 10); end
    end
    checks++; if (comp_done_cnt - c0 !== 1 || decomp_done_cnt - dd0 !== 0) begin
      errors++; $display("FAIL conf_done_cnt: got %0d/%0d expected 1/0", comp_done_cnt - c0, decomp_done_cnt - dd0); end
    checks++; if (wr_q.size() - w0 !== 64 || comp_size !== 14'd4096) begin
      errors++; $display("FAIL conf_result: got %0d/%0d expected 64/4096", wr_q.size() - w0, comp_size); end
  endtask

  task automatic test_reset_mid();
    int t, d, nf, p0, w0, c0, k;
    p0 = rd_ptr; c0 = comp_done_cnt;
    for (int i = 0; i < PB; i++) load_beat((i < 10) ? '0 : pat(32'h7700_0000 + i));
    pulse_start(1'b1, 1'b0, 1'b1, '0, t);
    for (k = 0; k < 200 && rd_ptr - p0 < 20; k++) @(negedge clk);
    checks++; if (rd_ptr - p0 !== 20) begin errors++; $display("FAIL mid_reach_beat20: got %0d expected 20", rd_ptr - p0); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %0b expected 0", busy); end
    checks++; if (comp_size !== 14'd0 || zbitmap !== 64'd0) begin
      errors++; $display("FAIL mid_cleared: got %0d/%0h expected 0/0", comp_size, zbitmap); end
    checks++; if ({fifo_if.wrfifo_valid_o, fifo_if.rdfifo_rready_o, comp_done, err} !== 4'b0000 || fifo_if.wrfifo_data_o !== '0) begin
      errors++; $display("FAIL mid_outputs: got %0b expected 0000", {fifo_if.wrfifo_valid_o, fifo_if.rdfifo_rready_o, comp_done, err}); end
    rd_len = rd_ptr;
    repeat (3) @(negedge clk);
    checks++; if (comp_done_cnt - c0 !== 0) begin errors++; $display("FAIL mid_no_done: got %0d expected 0", comp_done_cnt - c0); end
    w0 = wr_q.size();
    for (int i = 0; i < PB; i++) load_beat((i < 10) ? '0 : pat(32'h3300_0000 + i));
    pulse_start(1'b1, 1'b0, 1'b1, '0, t);
    wait_done(1'b1, 1'b0, 200, d, nf);
    checks++; if (d !== t + 65) begin errors++; $display("FAIL mid_restart_latency: got %0d expected %0d", d - t, 65); end
    @(negedge clk); @(negedge clk);
    checks++; if (comp_size !== 14'd3456) begin errors++; $display("FAIL mid_restart_size: got %0d expected 3456", comp_size); end
    checks++; if (zbitmap !== 64'h3FF) begin errors++; $display("FAIL mid_restart_bitmap: got %0h expected 3ff", zbitmap); end
    checks++; if (wr_q.size() - w0 !== 54) begin errors++; $display("FAIL mid_restart_writes: got %0d expected 54", wr_q.size() - w0); end
  endtask

  task automatic test_all_zero_page();
    int t, d, nf, p0, w0;
    p0 = rd_ptr; w0 = wr_q.size();
    for (int i = 0; i < PB; i++) load_beat('0);
    pulse_start(1'b1, 1'b0, 1'b1, '0, t);
    wait_done(1'b1, 1'b0, 200, d, nf);
    checks++; if (d !== t + 65) begin errors++; $display("FAIL zpage_latency: got %0d expected %0d", d - t, 65); end
    @(negedge clk); @(negedge clk);
    checks++; if (rd_ptr - p0 !== 64 || wr_q.size() - w0 !== 0) begin
      errors++; $display("FAIL zpage_counts: got %0d/%0d expected 64/0", rd_ptr - p0, wr_q.size() - w0); end
    checks++; if (comp_size !== 14'd0) begin errors++; $display("FAIL zpage_size: got %0d expected 0", comp_size); end
    checks++; if (zbitmap !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL zpage_bitmap: got %0h expected all ones", zbitmap); end
  endtask

  task automatic test_decomp_all_zero();
    int t, d, nf, p0, w0, nzw;
    p0 = rd_ptr; w0 = wr_q.size();
    pulse_start(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, t);
    wait_done(1'b0, 1'b0, 200, d, nf);
    checks++; if (d !== t + 65) begin errors++; $display("FAIL dz_latency: got %0d expected %0d", d - t, 65); end
    @(negedge clk); @(negedge clk);
    nzw = 0;
    for (int i = w0; i < wr_q.size(); i++) if (wr_q[i] !== '0) nzw++;
    checks++; if (rd_ptr - p0 !== 0 || wr_q.size() - w0 !== 64) begin
      errors++; $display("FAIL dz_counts: got %0d/%0d expected 0/64", rd_ptr - p0, wr_q.size() - w0); end
    checks++; if (nzw !== 0) begin errors++; $display("FAIL dz_data: got %0d nonzero beats expected 0", nzw); end
  endtask

  task automatic test_back_to_back();
    int t1, d1, t2, d2, nf, p0, w0, e0;
    p0 = rd_ptr; w0 = wr_q.size(); e0 = err_cnt;
    for (int i = 0; i < 2 * PB; i++) load_beat(pat(32'h5A00_0000 + i));
    pulse_start(1'b1, 1'b0, 1'b0, '0, t1);
    wait_done(1'b1, 1'b0, 200, d1, nf);
    pulse_start(1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, t2);
    checks++; if (t2 !== d1 + 1) begin errors++; $display("FAIL b2b_start_cycle: got %0d expected %0d", t2 - d1, 1); end
    wait_done(1'b0, 1'b0, 200, d2, nf);
    checks++; if (d2 !== t2 + 65) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", d2 - t2, 65); end
    @(negedge clk); @(negedge clk);
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL b2b_err: got %0d expected 0", err_cnt - e0); end
    checks++; if (rd_ptr - p0 !== 128 || wr_q.size() - w0 !== 128) begin
      errors++; $display("FAIL b2b_counts: got %0d/%0d expected 128/128", rd_ptr - p0, wr_q.size() - w0); end
    for (int i = 0; i < 2 * PB && w0 + i < wr_q.size(); i += 9) begin
      checks++; if (wr_q[w0 + i] !== pat(32'h5A00_0000 + i)) begin
        errors++; $display("FAIL b2b_data[%0d]: got %0h expected %0h", i, wr_q[w0 + i], pat(32'h5A00_0000 + i)); end
    end
  endtask

  initial begin
    rst          = 1'b1;
    comp_start   = 1'b0;
    decomp_start = 1'b0;
    mode         = 1'b0;
    dbitmap      = '0;
    wr_full      = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_comp_zero_elim();
    test_comp_bypass_full();
    test_decomp_bitmap();
    test_start_conflict();
    test_reset_mid();
    test_all_zero_page();
    test_decomp_all_zero();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hawk_comdecomp_engine.md
# hawk_comdecomp_engine

Parametrised page compression/decompression engine for the HAWK heap-compression path. It sits between the page read FIFO and the page write FIFO. In compress mode it streams one page of beats and drops all-zero beats, producing a zero-beat bitmap and a compressed size in bytes. In decompress mode it rebuilds a full page from non-zero beats plus a bitmap. A bypass mode copies pages unchanged, which keeps the legacy fixed-size behaviour.

## Interface
Parameters:
- DATA_W, 512, beat width in bits; must be a multiple of 8.
- PAGE_BEATS, 64, beats per page; must be a power of two and at least 2.
- SIZE_W, 14, width of comp_size_o; must hold PAGE_BEATS*DATA_W/8.

Ports:
- clk_i  in  1  clock; the only clock.
- rst_i  in  1  synchronous, active-high reset.
- comp_start_i  in  1  single-cycle pulse that starts compression.
- decomp_start_i  in  1  single-cycle pulse that starts decompression.
- mode_i  in  1  0 = bypass, 1 = zero-beat elimination; sampled at start.
- decomp_bitmap_i  in  PAGE_BEATS  bit i=1 means beat i is zero; sampled at decomp start.
- rdfifo_data_i  in  DATA_W  first-word-fall-through head of the read FIFO.
- rdfifo_empty_i  in  1  read FIFO empty.
- rdfifo_rready_o  out  1  pop strobe for the read FIFO.
- wrfifo_data_o  out  DATA_W  write data.
- wrfifo_valid_o  out  1  write strobe.
- wrfifo_full_i  in  1  write FIFO full.
- comp_size_o  out  SIZE_W  compressed size in bytes.
- zero_bitmap_o  out  PAGE_BEATS  zero-beat bitmap of the last compressed page.
- comp_done_o  out  1  one-cycle pulse when compression ends.
- decomp_done_o  out  1  one-cycle pulse when decompression ends.
- busy_o  out  1  high in every state except IDLE.
- err_o  out  1  one-cycle pulse when a start is rejected.

## Operation
- States: IDLE, COMP, DECOMP, DONE.
- A beat index counter (width $clog2(PAGE_BEATS)) and a non-zero beat counter (width $clog2(PAGE_BEATS)+1) both clear on entry to COMP or DECOMP.
- IDLE:
  - comp_start_i goes to COMP.
  - Otherwise decomp_start_i goes to DECOMP.
  - Both high: COMP wins and err_o pulses.
- COMP:
  - Pop condition: rdfifo_rready_o = !rdfifo_empty_i && !wrfifo_full_i. Stall on full even for zero beats.
  - On each pop: zero_bitmap_o[idx] <= (rdfifo_data_i == 0).
  - wrfifo_valid_o = pop && (mode==bypass || rdfifo_data_i != 0).
  - wrfifo_data_o = rdfifo_data_i.
  - The non-zero counter increments on each write; the index increments on each pop.
  - The pop at idx = PAGE_BEATS-1 moves to DONE.
- DECOMP, at index i:
  - bitmap[i]=1: write zeros when !wrfifo_full_i; no pop.
  - bitmap[i]=0: rdfifo_rready_o = !rdfifo_empty_i && !wrfifo_full_i; write rdfifo_data_i on pop.
  - In bypass mode the bitmap is treated as all zeros.
  - The index advances on each write; the last write moves to DONE.
- DONE:
  - Pulse comp_done_o or decomp_done_o (whichever operation ran), then return to IDLE.
  - After COMP: comp_size_o <= nz_cnt * (DATA_W/8), registered on entry to DONE.
  - In bypass mode this gives the full page size.
  - comp_size_o and zero_bitmap_o hold until the next compression starts.
- A start seen in COMP, DECOMP or DONE is ignored and err_o pulses.
- Decompression leaves comp_size_o and zero_bitmap_o untouched.

## Timing
- Reset: the FSM goes to IDLE and every output is 0, including comp_size_o, zero_bitmap_o and wrfifo_data_o.
- Reset mid-operation aborts immediately. No done pulse is produced and partial bitmap/size are cleared.
- The FIFO strobes are combinational from the state, the empty/full inputs and the held bitmap. They are never asserted in IDLE or DONE.
- Latency with no stalls:
  - Start at cycle T gives the first pop/write at T+1.
  - The done pulse is at T+PAGE_BEATS+1 (T+65 with the defaults).
  - busy_o is high from T+1 through T+PAGE_BEATS+1.
- Each empty/full stall cycle adds one cycle of latency. Nothing is lost or duplicated.
- All-zero page in mode 1: PAGE_BEATS pops, no writes, comp_size_o=0.
- All-ones bitmap in decompress: no pops; PAGE_BEATS zero writes.
- Back-to-back operation: a start in the cycle after the done pulse (state IDLE) is accepted.

## Structure
- hawk_comdecomp_pkg holds:
  - the state enum (IDLE/COMP/DECOMP/DONE);
  - the mode enum (MODE_BYPASS=0, MODE_ZERO_ELIM=1);
  - a function beat_bytes(DATA_W).
- No sub-module: the zero detect is a reduction compare and the counters are inline.

## Test plan
- Compress, mode 1, beats 0,2,4,… zero and the rest 0xA5 pattern, no stalls -> 32 writes, comp_size_o=2048, zero_bitmap_o=0x5555_5555_5555_5555, comp_done_o at T+65.
- Compress, mode 0, random data with wrfifo_full_i toggling 50% -> 64 writes in order, comp_size_o=4096, done delayed exactly by the number of full cycles.
- Decompress with bitmap 0xFFFF_FFFF_0000_0000 and 32 beats in the read FIFO -> 32 data beats followed by 32 zero beats, 32 pops, decomp_done_o pulse.
- comp_start_i and decomp_start_i together in IDLE, then comp_start_i at cycle T+10 -> compression runs, err_o pulses at T and at T+10, one done pulse only.
- rst_i asserted at beat 20 of a compression -> next cycle busy_o=0, all outputs 0, no comp_done_o; a new start completes normally.
